// File: rtl/alu_pkg.sv
// Shared types, op codes and helpers for the ALU arbiter.
// Op codes follow the external ALU's select encoding.
package alu_pkg;

  localparam int W_DEFAULT = 64;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;
  localparam logic [3:0] ALU_NOR   = 4'b1100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_t;

  function automatic logic op_legal(
    input logic [3:0] sel
  );
    case (sel)
      ALU_AND,
      ALU_OR,
      ALU_ADD,
      ALU_SUB,
      ALU_PASSB,
      ALU_NOR: op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side request/response bundle of the ALU arbiter.
// master = requesters, slave = arbiter.
interface alu_arbiter_if
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = W_DEFAULT
) ();

  logic [NREQ-1:0]   req_valid;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ*4-1:0] req_sel;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [W-1:0]      rsp_result;
  logic              rsp_zero;
  logic              rsp_err;

  modport master (
    output req_valid,
    output req_a,
    output req_b,
    output req_sel,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_result,
    input  rsp_zero,
    input  rsp_err
  );

  modport slave (
    input  req_valid,
    input  req_a,
    input  req_b,
    input  req_sel,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_result,
    output rsp_zero,
    output rsp_err
  );

endinterface

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or above ptr,
// wrapping modulo N. Purely combinational.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  logic [IW-1:0] idx;

  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    idx     = '0;
    gnt     = '0;
    for (int k = 0; k < N; k++) begin
      idx = IW'((int'(ptr) + k) % N);
      if (!any && req[idx]) begin
        any     = 1'b1;
        gnt_idx = idx;
      end
    end
    if (any) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external combinational ALU
// among NREQ requesters; one operation per three cycles.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int W    = W_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_arbiter_if.slave  bus,
  output logic          busy,
  output logic [W-1:0]  alu_a,
  output logic [W-1:0]  alu_b,
  output logic [3:0]    alu_sel,
  input  logic [W-1:0]  alu_out,
  input  logic          alu_z
);

  localparam int IW = $clog2(NREQ);

  state_t          state;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   gnt_idx;
  logic [NREQ-1:0] gnt;
  logic            any;
  logic [W-1:0]    pick_a;
  logic [W-1:0]    pick_b;
  logic [3:0]      pick_sel;
  logic            err_q;

  rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_pick (
    .req     (bus.req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  always_comb begin
    pick_a   = '0;
    pick_b   = '0;
    pick_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        pick_a   = bus.req_a[i*W +: W];
        pick_b   = bus.req_b[i*W +: W];
        pick_sel = bus.req_sel[i*4 +: 4];
      end
    end
  end

  assign bus.req_ready = (state == ST_IDLE) ? gnt : '0;
  assign busy          = (state != ST_IDLE);

  always_comb begin
    bus.rsp_valid = '0;
    if (state == ST_RESP) bus.rsp_valid[owner] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      rr_ptr         <= '0;
      owner          <= '0;
      alu_a          <= '0;
      alu_b          <= '0;
      alu_sel        <= ALU_AND;
      err_q          <= 1'b0;
      bus.rsp_result <= '0;
      bus.rsp_zero   <= 1'b0;
      bus.rsp_err    <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (any) begin
            alu_a  <= pick_a;
            alu_b  <= pick_b;
            err_q  <= !op_legal(pick_sel);
            // illegal codes never reach the ALU select
            if (op_legal(pick_sel)) alu_sel <= pick_sel;
            owner  <= gnt_idx;
            rr_ptr <= (gnt_idx == IW'(NREQ - 1)) ?
                      '0 : gnt_idx + IW'(1);
            state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          bus.rsp_result <= err_q ? '0 : alu_out;
          bus.rsp_zero   <= !err_q && alu_z;
          bus.rsp_err    <= err_q;
          state          <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready[owner]) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: vector table, corner sequences and
// random traffic against a transaction-level reference model.
module tb_alu_arbiter;

  localparam int NREQ = 2;
  localparam int W    = 64;
  localparam logic [63:0] ONES = '1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           busy;
  logic [W-1:0]   alu_a;
  logic [W-1:0]   alu_b;
  logic [3:0]     alu_sel;
  logic [W-1:0]   alu_out;
  logic           alu_z;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  alu_arbiter #(
    .NREQ (NREQ),
    .W    (W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .busy    (busy),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_sel (alu_sel),
    .alu_out (alu_out),
    .alu_z   (alu_z)
  );

  function automatic logic [63:0] ref_op(
    input logic [3:0] s,
    input logic [63:0] a,
    input logic [63:0] b
  );
    case (s)
      4'h0:    return a & b;
      4'h1:    return a | b;
      4'h2:    return a + b;
      4'h6:    return a - b;
      4'h7:    return b;
      4'hC:    return ~(a | b);
      default: return 64'hBAD0_BAD0_BAD0_BAD0;
    endcase
  endfunction

  function automatic bit legal(input logic [3:0] s);
    return s inside {4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC};
  endfunction

  function automatic logic [NREQ-1:0] oh(input int i);
    return NREQ'(1) << i;
  endfunction

  // external ALU model
  assign alu_out = ref_op(alu_sel, alu_a, alu_b);
  assign alu_z   = (alu_out == '0);

  task automatic chk(
    input string nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic set_req(
    input int i,
    input logic v,
    input logic [3:0] s,
    input logic [63:0] a,
    input logic [63:0] b
  );
    bus.req_valid[i]       = v;
    bus.req_sel[i*4 +: 4]  = s;
    bus.req_a[i*W +: W]    = a;
    bus.req_b[i*W +: W]    = b;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_sel   = '0;
    bus.rsp_ready = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    int          req;
    logic [3:0]  sel;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic        zero;
    logic        err;
  } vec_t;

  localparam int NV = 11;
  vec_t tbl [NV];

  logic [3:0]      opl [8];
  logic [3:0]      last_legal;
  logic [NREQ-1:0] pend;
  logic [3:0]      rs [NREQ];
  logic [63:0]     ra [NREQ];
  logic [63:0]     rb [NREQ];
  logic [63:0]     e_res;
  logic            e_zero;
  logic            e_err;
  logic [NREQ-1:0] e_rdy;
  logic [NREQ-1:0] e_vld;
  int              mptr;
  int              own;
  int              gcyc;
  int              w;
  int              j;
  bit              inflight;
  bit              e_busy;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{0, 4'h2, 64'd5,    64'd7,    64'd12,   1'b0, 1'b0};
    tbl[1]  = '{1, 4'h2, ONES,     64'd1,    64'd0,    1'b1, 1'b0};
    tbl[2]  = '{1, 4'h6, 64'h1234, 64'h1234, 64'd0,    1'b1, 1'b0};
    tbl[3]  = '{0, 4'h0, 64'hF0F0, 64'hFF00, 64'hF000, 1'b0, 1'b0};
    tbl[4]  = '{1, 4'h1, 64'h0F,   64'hF0,   64'hFF,   1'b0, 1'b0};
    tbl[5]  = '{0, 4'hC, 64'd0,    64'd0,    ONES,     1'b0, 1'b0};
    tbl[6]  = '{1, 4'h7, 64'd1,    64'hABCD, 64'hABCD, 1'b0, 1'b0};
    tbl[7]  = '{0, 4'h3, 64'd9,    64'd9,    64'd0,    1'b0, 1'b1};
    tbl[8]  = '{1, 4'h6, 64'd0,    64'd1,    ONES,     1'b0, 1'b0};
    tbl[9]  = '{0, 4'hF, 64'd0,    64'd0,    64'd0,    1'b0, 1'b1};
    tbl[10] = '{1, 4'hC, ONES,     64'd0,    64'd0,    1'b1, 1'b0};
    opl = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC, 4'h3, 4'hF};

    do_reset();
    #1;
    chk("rst ready",  bus.req_ready,  0);
    chk("rst valid",  bus.rsp_valid,  0);
    chk("rst busy",   busy,           0);
    chk("rst result", bus.rsp_result, 0);
    chk("rst zero",   bus.rsp_zero,   0);
    chk("rst err",    bus.rsp_err,    0);
    chk("rst alu",    {alu_sel, alu_a[59:0]} | alu_b, 0);

    // single transactions from the table
    last_legal = 4'h0;
    for (int v = 0; v < NV; v++) begin
      @(negedge clk);
      bus.rsp_ready = '1;
      set_req(tbl[v].req, 1'b1, tbl[v].sel, tbl[v].a, tbl[v].b);
      if (legal(tbl[v].sel)) last_legal = tbl[v].sel;
      #1 chk($sformatf("v%0d ready", v), bus.req_ready,
             oh(tbl[v].req));
      @(negedge clk);
      bus.req_valid = '0;
      #1 chk($sformatf("v%0d exec", v), bus.rsp_valid, 0);
      chk($sformatf("v%0d busy", v), busy, 1);
      @(negedge clk);
      #1;
      chk($sformatf("v%0d valid", v), bus.rsp_valid, oh(tbl[v].req));
      chk($sformatf("v%0d result", v), bus.rsp_result, tbl[v].res);
      chk($sformatf("v%0d zero", v), bus.rsp_zero, tbl[v].zero);
      chk($sformatf("v%0d err", v), bus.rsp_err, tbl[v].err);
      chk($sformatf("v%0d alu_sel", v), alu_sel, last_legal);
    end

    // two requesters held valid: alternate grants every 3 cycles
    do_reset();
    @(negedge clk);
    bus.rsp_ready = '1;
    set_req(0, 1'b1, 4'h1, 64'hF0, 64'h0F);
    set_req(1, 1'b1, 4'hC, 64'd0, 64'd0);
    for (int c = 0; c < 12; c++) begin
      #1;
      chk($sformatf("rr c%0d ready", c), bus.req_ready,
          (c % 3 == 0) ? oh((c / 3) % 2) : 0);
      if (c % 3 == 2) begin
        chk($sformatf("rr c%0d valid", c), bus.rsp_valid,
            oh(((c - 2) / 3) % 2));
        chk($sformatf("rr c%0d result", c), bus.rsp_result,
            (((c - 2) / 3) % 2 == 0) ? 64'hFF : ONES);
      end
      @(negedge clk);
    end
    bus.req_valid = '0;
    repeat (3) @(negedge clk);

    // response back-pressure on requester 0 while requester 1 waits
    do_reset();
    @(negedge clk);
    bus.rsp_ready = 2'b10;
    set_req(0, 1'b1, 4'h7, 64'd0, 64'hABCD);
    set_req(1, 1'b1, 4'h0, 64'hFF, 64'h0F);
    #1 chk("bp grant0", bus.req_ready, 2'b01);
    @(negedge clk);
    bus.req_valid[0] = 1'b0;
    #1 chk("bp exec valid", bus.rsp_valid, 0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp hold%0d valid", k), bus.rsp_valid, 2'b01);
      chk($sformatf("bp hold%0d result", k), bus.rsp_result, 64'hABCD);
      chk($sformatf("bp hold%0d ready", k), bus.req_ready, 0);
      @(negedge clk);
    end
    bus.rsp_ready = 2'b11;
    #1 chk("bp accept valid", bus.rsp_valid, 2'b01);
    chk("bp accept ready", bus.req_ready, 0);
    @(negedge clk);
    #1 chk("bp grant1", bus.req_ready, 2'b10);
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    #1 chk("bp result1", bus.rsp_result, 64'h0F);
    @(negedge clk);

    // reset pulsed during EXEC
    do_reset();
    @(negedge clk);
    bus.rsp_ready = '1;
    set_req(0, 1'b1, 4'h2, 64'd3, 64'd4);
    #1 chk("mr grant", bus.req_ready, 2'b01);
    @(negedge clk);
    bus.req_valid = '0;
    #1 chk("mr busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mr busy rst", busy, 0);
    chk("mr alu_a rst", alu_a, 0);
    chk("mr alu_b rst", alu_b, 0);
    chk("mr valid rst", bus.rsp_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1 chk($sformatf("mr none%0d", k), bus.rsp_valid, 0);
      @(negedge clk);
    end
    set_req(0, 1'b1, 4'h1, 64'd1, 64'd2);
    set_req(1, 1'b1, 4'h1, 64'd1, 64'd2);
    #1 chk("mr ptr0", bus.req_ready, 2'b01);
    @(negedge clk);
    bus.req_valid = '0;
    repeat (3) @(negedge clk);

    // random traffic against a transaction-level model
    do_reset();
    mptr       = 0;
    inflight   = 0;
    own        = 0;
    gcyc       = 0;
    pend       = '0;
    last_legal = 4'h0;
    e_res      = '0;
    e_zero     = 1'b0;
    e_err      = 1'b0;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          rs[i]   = opl[$urandom_range(0, 7)];
          ra[i]   = {$urandom, $urandom};
          rb[i]   = ($urandom_range(0, 3) == 0) ? ra[i]
                                                : {$urandom, $urandom};
        end
        set_req(i, pend[i], rs[i], ra[i], rb[i]);
      end
      bus.rsp_ready = NREQ'($urandom);
      #1;
      e_busy = inflight;
      e_rdy  = '0;
      if (!inflight && pend != 0) begin
        w = -1;
        for (int k = 0; k < NREQ; k++) begin
          j = (mptr + k) % NREQ;
          if (w < 0 && pend[j]) w = j;
        end
        e_rdy    = oh(w);
        inflight = 1;
        own      = w;
        gcyc     = n;
        mptr     = (w + 1) % NREQ;
        e_err    = !legal(rs[w]);
        e_res    = e_err ? 64'd0 : ref_op(rs[w], ra[w], rb[w]);
        e_zero   = !e_err && (e_res == 0);
        if (!e_err) last_legal = rs[w];
        pend[w]  = 1'b0;
      end
      chk($sformatf("rnd%0d ready", n), bus.req_ready, e_rdy);
      chk($sformatf("rnd%0d busy", n), busy, e_busy);
      e_vld = (inflight && n >= gcyc + 2) ? oh(own) : '0;
      chk($sformatf("rnd%0d valid", n), bus.rsp_valid, e_vld);
      if (e_vld != 0) begin
        chk($sformatf("rnd%0d result", n), bus.rsp_result, e_res);
        chk($sformatf("rnd%0d flags", n),
            {bus.rsp_zero, bus.rsp_err}, {e_zero, e_err});
        chk($sformatf("rnd%0d alu_sel", n), alu_sel, last_legal);
        if (bus.rsp_ready[own]) inflight = 0;
      end
    end

    @(negedge clk);
    bus.req_valid = '0;
    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
